// File: rtl/prach_tdm_source.sv
// PRACH TDM source: turns one parallel [cc][ant] sample set per frame into a
// free-running 48-slot TDM stream with a double-buffered shadow/output bank.

module prach_tdm_lane (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld,
   input  logic        xfer,
   input  logic [15:0] din_r,
   input  logic [15:0] din_i,
   output logic [15:0] bank_r,
   output logic [15:0] bank_i
);
   logic [15:0] sh_r, sh_i, ob_r, ob_i;

   always_ff @(posedge clk) begin
      if (ld) begin
         sh_r <= din_r;
         sh_i <= din_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ob_r <= '0;
         ob_i <= '0;
      end else if (xfer) begin
         ob_r <= sh_r;
         ob_i <= sh_i;
      end
   end

   // Bank contents as they will be after this edge, so the output mux can
   // present the first beat of a pass right after the transfer.
   assign bank_r = xfer ? sh_r : ob_r;
   assign bank_i = xfer ? sh_i : ob_i;
endmodule

module prach_tdm_source #(
   parameter int N_CC       = 3,
   parameter int N_ANT      = 8,
   parameter int CHN_STRIDE = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_CC-1:0][N_ANT-1:0][15:0]   s_dr,
   input  logic [N_CC-1:0][N_ANT-1:0][15:0]   s_di,
   input  logic                               s_dv,
   input  logic                               s_sync,
   output logic [15:0]                        dout_dr,
   output logic [15:0]                        dout_di,
   output logic                               dout_dv,
   output logic [7:0]                         dout_chn,
   output logic                               sync_out,
   output logic                               stat_ovf,
   output logic                               stat_udf,
   input  logic                               stat_clr
);
   localparam int         NSLOT = N_CC * CHN_STRIDE;
   localparam logic [7:0] LAST  = 8'(NSLOT - 1);

   typedef logic [N_CC-1:0][N_ANT-1:0][15:0] bank_t;

   logic [7:0]  slot, slot_nxt;
   logic        pend, act, frame, seen, sh_sync;
   logic        last, xfer, act_nxt, frame_nxt, ovf_set, udf_set;
   logic        dv_nxt;
   logic [15:0] dr_nxt, di_nxt;
   bank_t       bnk_r, bnk_i;

   for (genvar c = 0; c < N_CC; c++) begin : g_cc
      for (genvar a = 0; a < N_ANT; a++) begin : g_ant
         prach_tdm_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .ld     (s_dv),
            .xfer   (xfer),
            .din_r  (s_dr[c][a]),
            .din_i  (s_di[c][a]),
            .bank_r (bnk_r[c][a]),
            .bank_i (bnk_i[c][a])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (s_dv) sh_sync <= s_sync;
   end

   always_comb begin
      last      = (slot == LAST);
      slot_nxt  = last ? 8'd0 : slot + 8'd1;
      xfer      = last & pend;
      act_nxt   = last ? pend : act;
      frame_nxt = xfer ? sh_sync : (last ? 1'b0 : frame);
      // A set landing on the transfer slot is the next frame, not an overwrite.
      ovf_set   = s_dv & pend & ~last;
      udf_set   = last & ~pend & seen;
   end

   always_comb begin
      int s, cc, ant;
      s      = int'(slot_nxt);
      cc     = s / CHN_STRIDE;
      ant    = s % CHN_STRIDE;
      dv_nxt = act_nxt && (ant < N_ANT);
      dr_nxt = '0;
      di_nxt = '0;
      for (int c = 0; c < N_CC; c++) begin
         for (int a = 0; a < N_ANT; a++) begin
            if (dv_nxt && c == cc && a == ant) begin
               dr_nxt = bnk_r[c][a];
               di_nxt = bnk_i[c][a];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot     <= '0;
         pend     <= 1'b0;
         act      <= 1'b0;
         frame    <= 1'b0;
         seen     <= 1'b0;
         dout_dr  <= '0;
         dout_di  <= '0;
         dout_dv  <= 1'b0;
         sync_out <= 1'b0;
         stat_ovf <= 1'b0;
         stat_udf <= 1'b0;
      end else begin
         slot     <= slot_nxt;
         pend     <= s_dv | (pend & ~xfer);
         act      <= act_nxt;
         frame    <= frame_nxt;
         seen     <= seen | s_dv;
         dout_dr  <= dr_nxt;
         dout_di  <= di_nxt;
         dout_dv  <= dv_nxt;
         sync_out <= act_nxt & frame_nxt & (slot_nxt == 8'd0);
         stat_ovf <= ovf_set | (stat_ovf & ~stat_clr);
         stat_udf <= udf_set | (stat_udf & ~stat_clr);
      end
   end

   assign dout_chn = slot;
endmodule
